data_memory_subword: RTL

//  Next-generation MIPS data memory: byte-addressed, word-organised RAM with byte/half/word access,

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/data_memory_subword_if.sv | 26 ++
 rtl/dmem_byte_ram.sv | 26 ++
 rtl/data_memory_subword.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the sub-word data memory.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package dmem_pkg;

  // Access size encodings on size_i; 2'b11 is treated as a word access.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Controller state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Byte address that maps to word 0 unless overridden.
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

  // Little-endian lane enables for an access of the given size at a byte offset.
  function automatic logic [3:0] mask_for(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] m;
    case (size)
      SIZE_BYTE: m = 4'b0001 << offset;
      SIZE_HALF: m = offset[1] ? 4'b1100 : 4'b0011;
      default:   m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_memory_subword_if.sv
// Request/completion bus between the MEM-stage controller and the data memory.
// Latency: n/a (wiring only).
// Backpressure: the master may only expect acceptance while ready_o is high.
interface data_memory_subword_if;
  logic        req_i;
  logic        mem_write_i;
  logic        mem_read_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] address_i;
  logic [31:0] write_data_i;
  logic        ready_o;
  logic        done_o;
  logic [31:0] data_o;
  logic        error_o;

  modport master (
    output req_i, mem_write_i, mem_read_i, size_i, unsigned_i, address_i, write_data_i,
    input  ready_o, done_o, data_o, error_o
  );

  modport slave (
    input  req_i, mem_write_i, mem_read_i, size_i, unsigned_i, address_i, write_data_i,
    output ready_o, done_o, data_o, error_o
  );
endinterface

// File: rtl/dmem_byte_ram.sv
// Word-organised RAM with per-byte-lane write enables and an asynchronous read port.
// Latency: writes land on the rising edge; reads are combinational from the address.
// Backpressure: none; always accepts a write when any lane enable is set.
module dmem_byte_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Update only the enabled byte lanes; other lanes keep their contents.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (we[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_memory_subword.sv
// Byte/half/word data memory with sign/zero-extended loads; misaligned handling set by DMEM_MISALIGN_TRAP_EN.
// Latency: done_o pulses WAIT_STATES+1 edges after the accepting edge; back-to-back accept in the DONE cycle.
// Backpressure: ready_o is low while an access is in flight; requests are only taken when ready_o is high.
module data_memory_subword
  import dmem_pkg::*;
#(
  parameter int          DATA_WIDTH   = 32,
  parameter int          MEMORY_DEPTH = 1024,
  parameter int          WAIT_STATES  = 2,
  parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR
) (
  input  logic                 clk,
  input  logic                 reset,
  data_memory_subword_if.slave bus
);

  localparam int AW = $clog2(MEMORY_DEPTH);
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic                  wr_q;
  logic                  ready_q, done_q, err_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic                  accept, commit, misalign, fault;
  logic [1:0]            off;
  logic [31:0]           rel;
  logic [3:0]            we;
  logic [31:0]           ram_wdata, rdata, ld_val;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;

  assign accept   = bus.req_i & ready_q & (bus.mem_read_i | bus.mem_write_i);
  assign commit   = (state_q == ST_BUSY) && (cnt_q == '0);
  assign misalign = ((size_q == SIZE_HALF) & addr_q[0]) | (size_q[1] & (addr_q[1:0] != 2'b00));
  assign fault    = TRAP & misalign;
  assign rel      = addr_q - BASE_ADDR;

  // Effective byte offset: without trapping, misaligned low bits are simply dropped.
  always_comb begin
    off = addr_q[1:0];
    if (!TRAP) begin
      if (size_q[1])                  off = 2'b00;
      else if (size_q == SIZE_HALF)   off = {addr_q[1], 1'b0};
    end
  end

  // Replicate store data across lanes so the lane mask alone selects the target bytes.
  always_comb begin
    case (size_q)
      SIZE_BYTE: ram_wdata = {4{wdata_q[7:0]}};
      SIZE_HALF: ram_wdata = {2{wdata_q[15:0]}};
      default:   ram_wdata = wdata_q;
    endcase
  end

  // A store commits only at the final BUSY edge, never while reset is asserted or on a trapped fault.
  assign we = (commit && wr_q && reset && !fault) ? mask_for(size_q, off) : 4'b0000;

  dmem_byte_ram #(.DEPTH(MEMORY_DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (we),
    .addr  (rel[AW+1:2]),
    .wdata (ram_wdata),
    .rdata (rdata)
  );

  // Pick the addressed byte/half and sign- or zero-extend it.
  always_comb begin
    ld_byte = rdata[{off, 3'b000} +: 8];
    ld_half = off[1] ? rdata[31:16] : rdata[15:0];
    case (size_q)
      SIZE_BYTE: ld_val = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      SIZE_HALF: ld_val = {{16{~uns_q & ld_half[15]}}, ld_half};
      default:   ld_val = rdata;
    endcase
  end

  // Capture the request fields on accept; they stay stable for the whole access.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= bus.address_i;
      wdata_q <= bus.write_data_i;
      size_q  <= bus.size_i;
      uns_q   <= bus.unsigned_i;
      wr_q    <= bus.mem_write_i;
    end
  end

  // Controller: IDLE -> BUSY (wait states) -> DONE, with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            state_q <= ST_BUSY;
            cnt_q   <= CW'(WAIT_STATES);
            ready_q <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (cnt_q == '0) begin
            state_q <= ST_DONE;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            data_q  <= (wr_q || fault) ? '0 : ld_val;
            err_q   <= fault;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            state_q <= ST_BUSY;
            cnt_q   <= CW'(WAIT_STATES);
            ready_q <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready_o = ready_q;
  assign bus.done_o  = done_q;
  assign bus.data_o  = data_q;
  assign bus.error_o = err_q;

endmodule
